ysyx_23060203_scoreboard: RTL and testbench
===========================================

# ysyx_23060203_scoreboard

GPR scoreboard between the IDU and the EXU/LSU/WBU back end. It counts in-flight writes per architectural register and gives the IDU one combinational hazard signal. The IDU uses that signal to hold an instruction whose sources, or whose destination counter, are not yet safe. This replaces single-stage EXU-only RAW detection, so multi-cycle loads and multiply/divide can be in flight while younger independent instructions issue.

## Interface
- CNT_W, 2, width of each per-register pending counter; max in-flight writes per register = 2^CNT_W − 1
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- qry_rs1  in  5  rs1 of the instruction currently held in IDU
- qry_rs1_en  in  1  instruction reads rs1
- qry_rs2  in  5  rs2 of held instruction
- qry_rs2_en  in  1  instruction reads rs2
- qry_rd  in  5  rd of held instruction (0 = no write)
- stall  out  1  combinational; IDU must deassert out_valid while high
- rs1_busy  out  1  qry_rs1 has pending write (ignores qry_rs1_en)
- rs2_busy  out  1  qry_rs2 has pending write (ignores qry_rs2_en)
- iss_valid  in  1  IDU→EXU handshake fired this cycle
- iss_rd  in  5  rd of issuing instruction
- wb_valid  in  1  WBU commits a GPR write this cycle
- wb_rd  in  5  register being written
- clr  in  1  zero all counters (asserted only when back end is drained, e.g. after trap redirect)
- busy_vec  out  32  bit i = counter i nonzero; bit 0 always 0
- err  out  1  sticky protocol-violation flag

## Operation
- 31 counters cnt[1..31], CNT_W bits each; x0 is never tracked and is never busy.
- Next-state per register r, priority top-down:
  - clr: cnt = (iss_valid & iss_rd==r) ? 1 : 0; wb ignored.
  - inc = iss_valid & iss_rd==r, dec = wb_valid & wb_rd==r.
  - inc & ~dec: cnt+1. If cnt is saturated, hold cnt and set err.
  - dec & ~inc: cnt−1. If cnt==0, hold 0 and set err.
  - inc & dec: unchanged.
- busy(r) = cnt[r] != 0 (see Configuration for WB bypass).
- rs1_busy = busy(qry_rs1); rs2_busy = busy(qry_rs2).
- stall = (qry_rs1_en & rs1_busy) | (qry_rs2_en & rs2_busy) | (qry_rd!=0 & cnt[qry_rd] saturated).
- Saturation stall does not apply when the same-cycle wb_rd==qry_rd frees a slot.
- iss_valid while stall is high is a protocol violation: counters follow the normal rules and err is set.
- err clears only on reset.

## Timing
- Reset: all cnt = 0, busy_vec = 0, err = 0, stall = 0, rs1_busy = rs2_busy = 0.
- Counters update on posedge clock; issue at cycle N makes rd busy from cycle N+1.
- Commit at cycle N clears busy from cycle N+1 (without bypass).
- stall, rs*_busy and busy_vec are combinational from counters, qry_* and, with bypass, wb_*. They have no dependency on iss_*.
- No loop through the IDU handshake.
- Reset mid-operation discards all pending state; back-end writes arriving after reset with cnt==0 set err.

## Configuration
- Macro YSYX_23060203_SCB_WB_BYPASS_EN.
- Defined: busy(r) = cnt[r]!=0 & ~(wb_valid & wb_rd==r & cnt[r]==1). The consumer issues in the commit cycle, and the WBU→IDU GPR forward path must exist. busy_vec reflects the bypassed value.
- Undefined: busy(r) = cnt[r]!=0. The consumer issues one cycle after commit; there is no combinational path from wb_* to stall.

## Structure
- Shared package ysyx_23060203_pkg: default for SCB_CNT_W, typedef for the counter type, and the GPR_NUM = 32 constant.
- Sub-module ysyx_23060203_scb_cnt: one saturating up/down counter with inc, dec, clr, clr_set inputs and zero, sat, err outputs. Instantiate 31 copies via generate and OR-reduce err.
- Top level handles decode of iss_rd/wb_rd to one-hot, the query muxes, and the stall logic.

## Test plan
- Reset → busy_vec=0, err=0. Query rs1=5 with en → stall=0.
- Issue rd=5 at cycle 0 → cycle 1: busy_vec[5]=1 and qry_rs1=5,en → stall=1. wb rd=5 at cycle 3 → cycle 4 stall=0.
  - With bypass: stall=0 already in cycle 3.
- Issue rd=7 three times, no commits (CNT_W=2) → cnt=3, qry_rd=7 → stall=1. Same-cycle wb rd=7 → stall=0.
- Same-cycle iss_rd=9 and wb_rd=9 with cnt=1 → cnt stays 1.
  - Issue rd=0 → busy_vec unchanged. Query x0 → never busy.
- wb rd=4 with cnt=0 → err=1 and stays 1 until reset; cnt[4] stays 0.
- cnt[3]=2, cnt[6]=1, then clr with iss rd=6 → next cycle busy_vec has only bit 6 set and cnt[6]=1.

Source files
------------

// File: rtl/ysyx_23060203_pkg.sv
// Shared constants and types for the ysyx_23060203 core slice.
package ysyx_23060203_pkg;

  localparam int unsigned SCB_CNT_W = 2;
  localparam int unsigned GPR_NUM   = 32;

  typedef logic [SCB_CNT_W-1:0] scb_cnt_t;

endpackage

// File: rtl/ysyx_23060203_scb_cnt.sv
// One saturating up/down pending-write counter for a single GPR, with sticky
// over/underflow error.
module ysyx_23060203_scb_cnt
  import ysyx_23060203_pkg::*;
#(
  parameter int unsigned CNT_W = SCB_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  input  logic clr_set,
  output logic zero,
  output logic sat,
  output logic one,
  output logic err
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d;

  assign zero = (cnt_q == '0);
  assign sat  = &cnt_q;
  assign one  = (cnt_q == CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err;
    if (clr) begin
      cnt_d = clr_set ? CNT_W'(1) : '0;
    end else if (inc && !dec) begin
      if (sat) err_d = 1'b1;
      else     cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (zero) err_d = 1'b1;
      else      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err   <= err_d;
    end
  end

endmodule

// File: rtl/ysyx_23060203_scoreboard.sv
// GPR scoreboard: per-register in-flight write counters and the IDU hazard stall.
// Optional macro YSYX_23060203_SCB_WB_BYPASS_EN lets a commit release its consumer in-cycle.
module ysyx_23060203_scoreboard
  import ysyx_23060203_pkg::*;
#(
  parameter int unsigned CNT_W = SCB_CNT_W
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  qry_rs1,
  input  logic        qry_rs1_en,
  input  logic [4:0]  qry_rs2,
  input  logic        qry_rs2_en,
  input  logic [4:0]  qry_rd,
  output logic        stall,
  output logic        rs1_busy,
  output logic        rs2_busy,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        clr,
  output logic [31:0] busy_vec,
  output logic        err
);

  logic [GPR_NUM-1:1] iss_oh, wb_oh, zero_v, sat_v, one_v, err_v, busy_v;
  logic [GPR_NUM-1:0] sat_full;
  logic               sat_hit, viol_q;

  always_comb begin
    iss_oh = '0;
    wb_oh  = '0;
    for (int unsigned r = 1; r < GPR_NUM; r++) begin
      iss_oh[r] = iss_valid && (iss_rd == 5'(r));
      wb_oh[r]  = wb_valid && (wb_rd == 5'(r));
    end
  end

  for (genvar g = 1; g < GPR_NUM; g++) begin : g_cnt
    ysyx_23060203_scb_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clock   (clock),
      .reset   (reset),
      .inc     (iss_oh[g]),
      .dec     (wb_oh[g]),
      .clr     (clr),
      .clr_set (iss_oh[g]),
      .zero    (zero_v[g]),
      .sat     (sat_v[g]),
      .one     (one_v[g]),
      .err     (err_v[g])
    );
  end

`ifdef YSYX_23060203_SCB_WB_BYPASS_EN
  // The last outstanding write retiring this cycle is forwarded by the WBU.
  assign busy_v = ~zero_v & ~(wb_oh & one_v);
`else
  assign busy_v = ~zero_v;
  logic unused_one;
  assign unused_one = ^one_v;
`endif

  assign busy_vec = {busy_v, 1'b0};
  assign rs1_busy = busy_vec[qry_rs1];
  assign rs2_busy = busy_vec[qry_rs2];

  // A same-cycle commit to qry_rd frees a slot, so saturation need not block issue.
  assign sat_full = {sat_v, 1'b0};
  assign sat_hit  = (qry_rd != 5'd0) && sat_full[qry_rd] && !(wb_valid && (wb_rd == qry_rd));

  assign stall = (qry_rs1_en && rs1_busy) || (qry_rs2_en && rs2_busy) || sat_hit;

  always_ff @(posedge clock) begin
    if (reset)                   viol_q <= 1'b0;
    else if (iss_valid && stall) viol_q <= 1'b1;
  end

  assign err = viol_q || (|err_v);

endmodule

// File: tb/tb_ysyx_23060203_scoreboard.sv
// Scoreboard-style bench: stimulus queues expected outputs, a negedge monitor checks them.
module tb_ysyx_23060203_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  qry_rs1, qry_rs2, qry_rd, iss_rd, wb_rd;
  logic        qry_rs1_en, qry_rs2_en, iss_valid, wb_valid, clr;
  logic        stall, rs1_busy, rs2_busy, err;
  logic [31:0] busy_vec;

  localparam int unsigned SelStall = 0, SelBusy = 1, SelErr = 2, SelRs1 = 3, SelRs2 = 4;

  typedef struct {
    string       name;
    int unsigned sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  ysyx_23060203_scoreboard dut (
    .clock      (clock),
    .reset      (reset),
    .qry_rs1    (qry_rs1),
    .qry_rs1_en (qry_rs1_en),
    .qry_rs2    (qry_rs2),
    .qry_rs2_en (qry_rs2_en),
    .qry_rd     (qry_rd),
    .stall      (stall),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .clr        (clr),
    .busy_vec   (busy_vec),
    .err        (err)
  );

  task automatic expect_val(input string name, input int unsigned sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: the DUT outputs are combinational, so every queued expectation is
  // checked mid-cycle, away from the clock edge where inputs change.
  always @(negedge clock) begin
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        SelStall: act = {31'b0, stall};
        SelBusy:  act = busy_vec;
        SelErr:   act = {31'b0, err};
        SelRs1:   act = {31'b0, rs1_busy};
        default:  act = {31'b0, rs2_busy};
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    qry_rs1 = 5'd0; qry_rs2 = 5'd0; qry_rd = 5'd0; qry_rs1_en = 1'b0; qry_rs2_en = 1'b0;
    iss_valid = 1'b0; iss_rd = 5'd0; wb_valid = 1'b0; wb_rd = 5'd0; clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    qry_rs1 = 5'd5; qry_rs1_en = 1'b1;
    expect_val("reset_busy_vec", SelBusy, 32'h0);
    expect_val("reset_err", SelErr, 32'h0);
    expect_val("reset_stall", SelStall, 32'h0);
    expect_val("reset_rs1_busy", SelRs1, 32'h0);
    tick();

    // RAW on x5: issue, wait, commit
    iss_valid = 1'b1; iss_rd = 5'd5;
    expect_val("issue_cycle_no_stall", SelStall, 32'h0);
    tick();
    iss_valid = 1'b0;
    expect_val("raw_busy_vec", SelBusy, 32'h20);
    expect_val("raw_stall", SelStall, 32'h1);
    expect_val("raw_rs1_busy", SelRs1, 32'h1);
    tick();
    expect_val("raw_stall_hold", SelStall, 32'h1);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd5;
`ifdef YSYX_23060203_SCB_WB_BYPASS_EN
    expect_val("commit_cycle_stall", SelStall, 32'h0);
`else
    expect_val("commit_cycle_stall", SelStall, 32'h1);
`endif
    tick();
    wb_valid = 1'b0;
    expect_val("after_commit_stall", SelStall, 32'h0);
    expect_val("after_commit_busy_vec", SelBusy, 32'h0);
    tick();

    // Saturate x7
    qry_rs1_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iss_valid = 1'b1; iss_rd = 5'd7;
      tick();
    end
    iss_valid = 1'b0;
    qry_rd = 5'd7; qry_rs2 = 5'd7; qry_rs2_en = 1'b0;
    expect_val("sat_stall", SelStall, 32'h1);
    expect_val("sat_rs2_busy_ignores_en", SelRs2, 32'h1);
    expect_val("sat_busy_vec", SelBusy, 32'h80);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd7;
    expect_val("sat_freed_by_wb_stall", SelStall, 32'h0);
    expect_val("sat_freed_busy_vec", SelBusy, 32'h80);
    tick();
    wb_valid = 1'b0;
    expect_val("cnt2_no_sat_stall", SelStall, 32'h0);
    expect_val("sat_no_err", SelErr, 32'h0);
    tick();
    qry_rd = 5'd0;

    // Simultaneous issue and commit on x9 with cnt=1
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    wb_valid = 1'b1; wb_rd = 5'd9;
`ifdef YSYX_23060203_SCB_WB_BYPASS_EN
    expect_val("x9_same_cycle_busy_vec", SelBusy, 32'h80);
`else
    expect_val("x9_same_cycle_busy_vec", SelBusy, 32'h280);
`endif
    tick();
    wb_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd0;
    qry_rs1 = 5'd0; qry_rs1_en = 1'b1; qry_rs2 = 5'd0; qry_rs2_en = 1'b1;
    expect_val("x9_cnt_held_busy_vec", SelBusy, 32'h280);
    expect_val("x0_stall", SelStall, 32'h0);
    expect_val("x0_rs1_busy", SelRs1, 32'h0);
    tick();
    iss_valid = 1'b0;
    qry_rs1_en = 1'b0; qry_rs2_en = 1'b0;
    expect_val("issue_x0_busy_vec", SelBusy, 32'h280);
    tick();

    // Underflow on x4
    wb_valid = 1'b1; wb_rd = 5'd4;
    tick();
    wb_valid = 1'b0;
    expect_val("underflow_err", SelErr, 32'h1);
    expect_val("underflow_busy_vec", SelBusy, 32'h280);
    tick();
    tick();
    expect_val("err_sticky", SelErr, 32'h1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_val("reset_clears_err", SelErr, 32'h0);
    expect_val("reset_clears_busy", SelBusy, 32'h0);
    tick();

    // clr with concurrent issue to x6
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    tick();
    iss_rd = 5'd6;
    tick();
    iss_valid = 1'b0;
    expect_val("pre_clr_busy_vec", SelBusy, 32'h48);
    clr = 1'b1; iss_valid = 1'b1; iss_rd = 5'd6;
    tick();
    clr = 1'b0; iss_valid = 1'b0;
    expect_val("post_clr_busy_vec", SelBusy, 32'h40);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd6;
    tick();
    wb_valid = 1'b0;
    expect_val("x6_cnt_was_one_busy", SelBusy, 32'h0);
    expect_val("x6_cnt_was_one_err", SelErr, 32'h0);
    tick();

    // Issue while stalled
    iss_valid = 1'b1; iss_rd = 5'd6;
    tick();
    iss_rd = 5'd10; qry_rs1 = 5'd6; qry_rs1_en = 1'b1;
    expect_val("viol_stall", SelStall, 32'h1);
    expect_val("viol_err_before", SelErr, 32'h0);
    tick();
    iss_valid = 1'b0;
    expect_val("viol_err", SelErr, 32'h1);
    expect_val("viol_busy_vec", SelBusy, 32'h440);
    tick();

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
